// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Two-master arbiter for the shared data-memory / external bus.
//             Master 0 is the CPU memory stage, master 1 a secondary
//             requester (DMA / debug loader). One owner at a time,
//             round-robin with a bounded hold. The slave side is muxed from
//             the owner, and cs is decoded from the owner's address.
//  Ports    : clk, rst (async, active-low)
//             m0_* / m1_*    : req, we, addr, wdata in; gnt, rvalid out
//             m_rdata        : shared read data, qualified by mX_rvalid
//             ADDR, Data_BUS_WRITE, wr_rd, cs : bus outputs
//             Data_BUS_READ  : bus read data, valid the cycle after a read beat
//  Options  : ARB_FIXED_PRIO_EN - master 0 always wins ties and pre-empts
//             master 1 the cycle after m0_req rises (default: round-robin).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INT_SIZE = 1024,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_BUS_WRITE,
  input  logic [DATA_W-1:0] Data_BUS_READ,
  output logic              wr_rd,
  output logic              cs
);

  localparam int                 c_HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);
  localparam logic [ADDR_W-1:0]   c_INT_SIZE  = ADDR_W'(INT_SIZE);

  // One-hot-style encoding: bit 0 is the master 0 grant, bit 1 the master 1
  // grant, so both grants come straight from state flops.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t              r_state;
  logic                r_last_owner;   // 1 = master 1 was the most recent owner
  logic [c_HOLD_W-1:0] r_hold;
  logic                r_m0_rvalid;
  logic                r_m1_rvalid;

  logic                w_m0_beat;
  logic                w_m1_beat;
  logic                w_tie_to_m0;
  logic                w_owned;
  logic                w_own_we;
  logic                w_own_req;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  assign w_m0_beat = r_state[0] & m0_req;
  assign w_m1_beat = r_state[1] & m1_req;

`ifdef ARB_FIXED_PRIO_EN
  assign w_tie_to_m0 = 1'b1;
`else
  assign w_tie_to_m0 = r_last_owner;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
      r_hold       <= '0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
    end else begin
      r_m0_rvalid <= w_m0_beat & ~m0_we;
      r_m1_rvalid <= w_m1_beat & ~m1_we;
      case (r_state)
        ST_IDLE: begin
          r_hold <= '0;
          if (m0_req && (!m1_req || w_tie_to_m0)) begin
            r_state      <= ST_OWN0;
            r_last_owner <= 1'b0;
          end else if (m1_req) begin
            r_state      <= ST_OWN1;
            r_last_owner <= 1'b1;
          end
        end
        ST_OWN0: begin
          if (!m0_req) begin
            // Owner released: hand straight over if master 1 is waiting.
            r_hold <= '0;
            if (m1_req) begin
              r_state      <= ST_OWN1;
              r_last_owner <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (!m1_req) begin
            r_hold <= '0;      // uncontended: ownership is unlimited
`ifdef ARB_FIXED_PRIO_EN
          end else begin
            r_hold <= '0;      // master 0 is never pre-empted
          end
`else
          end else if (r_hold == c_HOLD_LAST) begin
            r_hold       <= '0;
            r_state      <= ST_OWN1;
            r_last_owner <= 1'b1;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
`endif
        end
        ST_OWN1: begin
`ifdef ARB_FIXED_PRIO_EN
          // Master 0 pre-empts; master 1's beat on this edge still completes.
          r_hold <= '0;
          if (m0_req) begin
            r_state      <= ST_OWN0;
            r_last_owner <= 1'b0;
          end else if (!m1_req) begin
            r_state <= ST_IDLE;
          end
`else
          if (!m1_req) begin
            r_hold <= '0;
            if (m0_req) begin
              r_state      <= ST_OWN0;
              r_last_owner <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (!m0_req) begin
            r_hold <= '0;
          end else if (r_hold == c_HOLD_LAST) begin
            r_hold       <= '0;
            r_state      <= ST_OWN0;
            r_last_owner <= 1'b0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_hold  <= '0;
        end
      endcase
    end
  end

  // Slave-side mux from the current owner; everything is zero while idle.
  always_comb begin
    w_owned   = 1'b0;
    w_own_we  = 1'b0;
    w_own_req = 1'b0;
    w_addr    = '0;
    w_wdata   = '0;
    if (r_state == ST_OWN0) begin
      w_owned   = 1'b1;
      w_own_we  = m0_we;
      w_own_req = m0_req;
      w_addr    = m0_addr;
      w_wdata   = m0_wdata;
    end else if (r_state == ST_OWN1) begin
      w_owned   = 1'b1;
      w_own_we  = m1_we;
      w_own_req = m1_req;
      w_addr    = m1_addr;
      w_wdata   = m1_wdata;
    end
  end

  assign ADDR           = w_addr;
  assign Data_BUS_WRITE = w_wdata;
  assign wr_rd          = w_own_we & w_own_req & w_owned;
  assign cs             = w_owned & (w_addr >= c_INT_SIZE);

  assign m0_gnt    = r_state[0];
  assign m1_gnt    = r_state[1];
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m_rdata   = Data_BUS_READ;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed self-checking bench for mem_bus_arbiter (default
//             build, MAX_HOLD=8, INT_SIZE=1024).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m_rdata, ADDR, Data_BUS_WRITE, Data_BUS_READ;
  logic        wr_rd, cs;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .INT_SIZE(1024), .MAX_HOLD(8)
  ) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m_rdata(m_rdata), .ADDR(ADDR), .Data_BUS_WRITE(Data_BUS_WRITE),
    .Data_BUS_READ(Data_BUS_READ), .wr_rd(wr_rd), .cs(cs)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 ns after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    Data_BUS_READ = '0;

    // ---------------- reset and idle ----------------
    repeat (3) step();
    check_val("rst_gnt", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("idle_out", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, wr_rd, cs, ADDR}, 38'h0);
      check_val("idle_wdata", Data_BUS_WRITE, 32'h0);
      step();
    end

    // ---------------- m0 write 0x10 then read 0x10 ----------------
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    #1 check_val("wr_lat0", m0_gnt, 1'b0);
    step();                                   // granted one cycle after req
    check_val("wr_gnt", {m0_gnt, m1_gnt}, 2'b10);
    check_val("wr_wr_rd", wr_rd, 1'b1);
    check_val("wr_addr", ADDR, 32'h10);
    check_val("wr_wdata", Data_BUS_WRITE, 32'hDEADBEEF);
    check_val("wr_cs", cs, 1'b0);
    step();                                   // write beat taken
    m0_we = 0;
    #1 check_val("wr_no_rvalid", m0_rvalid, 1'b0);
    check_val("rd_wr_rd", wr_rd, 1'b0);
    step();                                   // read beat taken
    m0_req = 0; Data_BUS_READ = 32'hDEADBEEF;
    #1 check_val("rd_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    check_val("rd_rdata", m_rdata, 32'hDEADBEEF);
    step();
    check_val("rd_after", {m0_gnt, m1_gnt, m0_rvalid, ADDR}, 35'h0);

    // ---------------- m1 read external 0x400 ----------------
    m1_req = 1; m1_we = 0; m1_addr = 32'h400;
    step();
    check_val("m1_gnt", {m0_gnt, m1_gnt}, 2'b01);
    check_val("m1_cs", cs, 1'b1);
    check_val("m1_wr_rd", wr_rd, 1'b0);
    check_val("m1_addr", ADDR, 32'h400);
    step();
    m1_req = 0; Data_BUS_READ = 32'h12345678;
    #1 check_val("m1_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    check_val("m1_rdata", m_rdata, 32'h12345678);
    step();
    check_val("m1_rvalid_pulse", m1_rvalid, 1'b0);

    // ---------------- internal boundary 0x3FF ----------------
    m0_req = 1; m0_we = 0; m0_addr = 32'h3FF;
    step();
    check_val("bnd_cs", {m0_gnt, cs}, 2'b10);
    step();
    m0_req = 0;
    step();

    // ---------------- reset mid-read ----------------
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    step();
    step();                                   // read beat done, rvalid up
    check_val("mid_rvalid", {m1_gnt, m1_rvalid}, 2'b11);
    rst = 1'b0;
    #1 check_val("async_rst", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 4'b0000);
    m1_req = 0;
    #3 rst = 1'b1;

    // ---------------- contention from reset ----------------
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    #1 check_val("cont_lat0", {m0_gnt, m1_gnt}, 2'b00);
    step();
    for (int k = 0; k < 32; k++) begin
      check_val("cont_gnt", {m0_gnt, m1_gnt}, ((k / 8) % 2 == 0) ? 2'b10 : 2'b01);
      check_val("cont_addr", ADDR, ((k / 8) % 2 == 0) ? 32'h100 : 32'h200);
      step();
    end

    // ---------------- handover on simultaneous drop/raise ----------------
    check_val("ho_m0_owns", {m0_gnt, m1_gnt}, 2'b10);
    m1_req = 0;
    step();
    m0_req = 0; m1_req = 1;
    step();
    check_val("ho_m1_next", {m0_gnt, m1_gnt}, 2'b01);
    for (int i = 0; i < 20; i++) begin
      check_val("m1_alone", {m0_gnt, m1_gnt}, 2'b01);
      step();
    end
    // Hold count stayed 0 while uncontended, so m1 keeps 8 more beats.
    m0_req = 1;
    for (int j = 0; j <= 8; j++) begin
      check_val("hold_after_alone", {m0_gnt, m1_gnt}, (j < 8) ? 2'b01 : 2'b10);
      step();
    end

    m0_req = 0; m1_req = 0;
    step();
    step();
    check_val("end_idle", {m0_gnt, m1_gnt, wr_rd, cs}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
